wbk_stage: RTL and testbench
============================

// Module: wbk_stage
// PURPOSE
//  Writeback stage directly downstream of the mem stage. Drains the mem2wbk FIFO.
//  Merges multiplier results for entries tagged MULT_INST. Owns the 32x32 integer
//  register file (two combinational read ports for decode). Publishes the write
//  port for hazard logic and counts retired instructions.
// PARAMETERS
//  NB_REG      32  number of architectural registers; x0 is hardwired to zero
//  RETIRE_W    64  width of the retired-instruction counter
// PORTS
//  clk              in   1   clock; all state updates on the rising edge
//  reset_n          in   1   synchronous active-low reset
//  MEM_RES_RM       in   32  mem result (ALU result or load data)
//  MEM_DEST_RM      in   6   destination; [4:0] selects the register, [5] ignored
//  WB_RM            in   1   entry writes the register file
//  CSR_WENABLE_RM   in   1   CSR instruction; rd receives CSR_RDATA_RM
//  CSR_RDATA_RM     in   32  old CSR value
//  MULT_INST_RM     in   1   rd data comes from the multiplier FIFO
//  MEM2WBK_EMPTY_SM in   1   mem2wbk FIFO empty
//  MEM2WBK_POP_SW   out  1   pop mem2wbk FIFO
//  MULT_RES_RX      in   32  multiplier FIFO head data
//  MULT_EMPTY_SX    in   1   multiplier FIFO empty
//  MULT_POP_SW      out  1   pop multiplier FIFO
//  RADR1_SD         in   5   read address, port 1
//  RADR2_SD         in   5   read address, port 2
//  RDATA1_SW        out  32  read data, port 1
//  RDATA2_SW        out  32  read data, port 2
//  REG_WB_SW        out  1   register write this cycle (addr != 0)
//  REG_DEST_SW      out  5   register write address
//  REG_DATA_SW      out  32  register write data
//  INSTRET_SW       out  64  retired-entry count
//  WAIT_MULT_SW     out  1   FSM is in WAIT_MULT
// BEHAVIOUR
//  - FSM states: RUN, WAIT_MULT. Reset state is RUN.
//  - RUN, FIFO not empty, MULT_INST_RM=0: pop this cycle; stay in RUN.
//  - RUN, FIFO not empty, MULT_INST_RM=1, MULT_EMPTY_SX=0: pop both FIFOs in the same cycle.
//  - RUN, FIFO not empty, MULT_INST_RM=1, MULT_EMPTY_SX=1: no pop; go to WAIT_MULT.
//  - WAIT_MULT: the head entry is held. When MULT_EMPTY_SX=0, pop both FIFOs and
//    return to RUN. Otherwise stay.
//  - MEM2WBK_POP_SW = !MEM2WBK_EMPTY_SM && (!MULT_INST_RM || !MULT_EMPTY_SX).
//  - MULT_POP_SW = MEM2WBK_POP_SW && MULT_INST_RM.
//  - Both pops are combinational, one entry per cycle max, and never asserted while reset_n=0.
//  - Write data priority: MULT_INST_RM -> MULT_RES_RX; CSR_WENABLE_RM -> CSR_RDATA_RM;
//    else MEM_RES_RM.
//  - REG_WB_SW = MEM2WBK_POP_SW && WB_RM && MEM_DEST_RM[4:0]!=0.
//  - The RF is written at the clock edge ending the pop cycle (0-cycle latency from pop).
//  - Writes to x0 are discarded. Reads of x0 return 0.
//  - INSTRET_SW increments by 1 per MEM2WBK_POP_SW (WB=0 entries included) and wraps
//    modulo 2^RETIRE_W.
//  - Reset (any cycle, including WAIT_MULT): state=RUN, all registers=0, INSTRET_SW=0,
//    WAIT_MULT_SW=0, REG_WB_SW=0. A held FIFO entry is not consumed.
//  - MULT FIFO non-empty while the head entry has MULT_INST_RM=0: the multiplier
//    FIFO is not popped.
// CONFIGURATION
//  WBK_RF_BYPASS_EN defined:
//   - A read whose address equals REG_DEST_SW while REG_WB_SW=1 returns REG_DATA_SW
//     in the same cycle.
//  WBK_RF_BYPASS_EN undefined:
//   - Reads return the stored value; the new value is visible the cycle after the write.
//   - Decode must stall on REG_DEST_SW match.
// TESTING
//  1. Reset: reset_n=0 for 2 cycles -> RDATA1/2=0 for every address, INSTRET_SW=0,
//     no pops.
//  2. Push {RES=0xDEADBEEF, DEST=5, WB=1} -> pop in the same cycle, REG_WB_SW=1, x5
//     reads 0xDEADBEEF next cycle, INSTRET_SW=1.
//  3. MULT entry with MULT_EMPTY_SX=1 for 3 cycles, then MULT_RES_RX=0x12345678 ->
//     WAIT_MULT_SW=1 for 3 cycles, no pop. Then both FIFOs pop in one cycle and rd reads
//     0x12345678.
//  4. CSR entry {CSR_WENABLE=1, CSR_RDATA=0x1800, RES=0x55, DEST=7} -> x7=0x1800.
//     Write to DEST=0 with 0xFFFFFFFF -> x0 still reads 0, REG_WB_SW=0.
//  5. WBK_RF_BYPASS_EN on, RADR1_SD=9 while writing x9=0xA5A5A5A5 -> RDATA1_SW=0xA5A5A5A5
//     in the same cycle. Macro off -> old value that cycle, new value next cycle.
//  6. reset_n=0 asserted while in WAIT_MULT -> state RUN, INSTRET_SW=0, entry still in
//     FIFO. After release, entry retires once the multiplier FIFO is non-empty.

Source files
------------

// File: rtl/wbk_stage_if.sv
// Writeback-side view of the mem2wbk FIFO head and the multiplier FIFO head.
// master: the FIFO side (drives head data/empty flags, receives pops).
// slave : the writeback stage (reads head data/empty flags, drives pops).
interface wbk_stage_if;
    localparam int unsigned XLEN   = 32;
    localparam int unsigned DEST_W = 6;

    // mem2wbk FIFO head entry
    logic [XLEN-1:0]   MEM_RES_RM;
    logic [DEST_W-1:0] MEM_DEST_RM;
    logic              WB_RM;
    logic              CSR_WENABLE_RM;
    logic [XLEN-1:0]   CSR_RDATA_RM;
    logic              MULT_INST_RM;
    logic              MEM2WBK_EMPTY_SM;
    logic              MEM2WBK_POP_SW;

    // multiplier FIFO head
    logic [XLEN-1:0]   MULT_RES_RX;
    logic              MULT_EMPTY_SX;
    logic              MULT_POP_SW;

    modport master (
        output MEM_RES_RM, MEM_DEST_RM, WB_RM, CSR_WENABLE_RM, CSR_RDATA_RM,
               MULT_INST_RM, MEM2WBK_EMPTY_SM, MULT_RES_RX, MULT_EMPTY_SX,
        input  MEM2WBK_POP_SW, MULT_POP_SW
    );

    modport slave (
        input  MEM_RES_RM, MEM_DEST_RM, WB_RM, CSR_WENABLE_RM, CSR_RDATA_RM,
               MULT_INST_RM, MEM2WBK_EMPTY_SM, MULT_RES_RX, MULT_EMPTY_SX,
        output MEM2WBK_POP_SW, MULT_POP_SW
    );
endinterface : wbk_stage_if

// File: rtl/wbk_stage.sv
// Writeback stage: drains the mem2wbk FIFO, merges multiplier results, owns the
// integer register file, publishes the write port and counts retired entries.
// Optional feature macro: WBK_RF_BYPASS_EN -- when defined, a read that hits the
// register being written this cycle returns the write data in the same cycle.
module wbk_stage #(
    parameter int unsigned NB_REG   = 32,
    parameter int unsigned RETIRE_W = 64
) (
    input  logic                clk,
    input  logic                reset_n,
    wbk_stage_if.slave          mif,
    input  logic [4:0]          RADR1_SD,
    input  logic [4:0]          RADR2_SD,
    output logic [31:0]         RDATA1_SW,
    output logic [31:0]         RDATA2_SW,
    output logic                REG_WB_SW,
    output logic [4:0]          REG_DEST_SW,
    output logic [31:0]         REG_DATA_SW,
    output logic [RETIRE_W-1:0] INSTRET_SW,
    output logic                WAIT_MULT_SW
);
    localparam int unsigned XLEN   = 32;
    localparam int unsigned ADDR_W = 5;

    typedef enum logic [0:0] {
        ST_RUN       = 1'b0,
        ST_WAIT_MULT = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic [XLEN-1:0]      rf_q [NB_REG];
    logic [RETIRE_W-1:0]  instret_q, instret_d;

    logic                 head_valid_c;
    logic                 mult_ready_c;
    logic                 mem_pop_c;
    logic                 mult_pop_c;
    logic                 wr_en_c;
    logic [ADDR_W-1:0]    wr_addr_c;
    logic [XLEN-1:0]      wr_data_c;
    logic [XLEN-1:0]      rdata1_c;
    logic [XLEN-1:0]      rdata2_c;
    logic                 dest_hi_unused;

    // Bit 5 of the destination tag is not part of the register address.
    assign dest_hi_unused = mif.MEM_DEST_RM[5];

    // Next state and FIFO pops; nothing is consumed while reset is asserted.
    always_comb begin
        state_d      = state_q;
        head_valid_c = 1'b0;
        mult_ready_c = 1'b0;
        mem_pop_c    = 1'b0;
        mult_pop_c   = 1'b0;
        if (reset_n) begin
            head_valid_c = !mif.MEM2WBK_EMPTY_SM;
            mult_ready_c = !mif.MULT_INST_RM || !mif.MULT_EMPTY_SX;
            mem_pop_c    = head_valid_c && mult_ready_c;
            mult_pop_c   = mem_pop_c && mif.MULT_INST_RM;
            case (state_q)
                ST_RUN: begin
                    if (head_valid_c && mif.MULT_INST_RM && mif.MULT_EMPTY_SX) begin
                        state_d = ST_WAIT_MULT;
                    end
                end
                ST_WAIT_MULT: begin
                    // Leave once the held entry retires (or vanishes defensively).
                    if (mem_pop_c || !head_valid_c) begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Write port: multiplier result beats CSR old value beats mem result.
    always_comb begin
        wr_addr_c = mif.MEM_DEST_RM[ADDR_W-1:0];
        wr_en_c   = mem_pop_c && mif.WB_RM && (wr_addr_c != ADDR_W'(0));
        if (mif.MULT_INST_RM) begin
            wr_data_c = mif.MULT_RES_RX;
        end else if (mif.CSR_WENABLE_RM) begin
            wr_data_c = mif.CSR_RDATA_RM;
        end else begin
            wr_data_c = mif.MEM_RES_RM;
        end
    end

    // Register file storage; x0 is never written.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(NB_REG); i++) begin
                rf_q[i] <= '0;
            end
        end else if (wr_en_c) begin
            rf_q[wr_addr_c] <= wr_data_c;
        end
    end

    // Retired-entry counter, one per mem2wbk pop, wraps naturally.
    always_comb begin
        instret_d = instret_q;
        if (mem_pop_c) begin
            instret_d = instret_q + RETIRE_W'(1);
        end
    end

    // Retired-entry counter register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            instret_q <= '0;
        end else begin
            instret_q <= instret_d;
        end
    end

    // Combinational read ports for decode; x0 always reads zero.
    always_comb begin
        rdata1_c = rf_q[RADR1_SD];
        rdata2_c = rf_q[RADR2_SD];
`ifdef WBK_RF_BYPASS_EN
        if (wr_en_c && (RADR1_SD == wr_addr_c)) begin
            rdata1_c = wr_data_c;
        end
        if (wr_en_c && (RADR2_SD == wr_addr_c)) begin
            rdata2_c = wr_data_c;
        end
`endif
        if (RADR1_SD == ADDR_W'(0)) begin
            rdata1_c = '0;
        end
        if (RADR2_SD == ADDR_W'(0)) begin
            rdata2_c = '0;
        end
    end

    assign mif.MEM2WBK_POP_SW = mem_pop_c;
    assign mif.MULT_POP_SW    = mult_pop_c;
    assign RDATA1_SW          = rdata1_c;
    assign RDATA2_SW          = rdata2_c;
    assign REG_WB_SW          = wr_en_c;
    assign REG_DEST_SW        = wr_addr_c;
    assign REG_DATA_SW        = wr_data_c;
    assign INSTRET_SW         = instret_q;
    assign WAIT_MULT_SW       = (state_q == ST_WAIT_MULT);

endmodule : wbk_stage

// File: tb/tb_wbk_stage.sv
// Directed bench for wbk_stage: reset, plain/mult/CSR/x0 writebacks, WAIT_MULT
// stall, optional read bypass, and reset taken while stalled.
module tb_wbk_stage;
    logic        clk;
    logic        reset_n;
    logic [4:0]  radr1;
    logic [4:0]  radr2;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
    logic        reg_wb;
    logic [4:0]  reg_dest;
    logic [31:0] reg_data;
    logic [63:0] instret;
    logic        wait_mult;

    int vectors     = 0;
    int miscompares = 0;

    wbk_stage_if bus ();

    wbk_stage #(
        .NB_REG   (32),
        .RETIRE_W (64)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .mif          (bus),
        .RADR1_SD     (radr1),
        .RADR2_SD     (radr2),
        .RDATA1_SW    (rdata1),
        .RDATA2_SW    (rdata2),
        .REG_WB_SW    (reg_wb),
        .REG_DEST_SW  (reg_dest),
        .REG_DATA_SW  (reg_data),
        .INSTRET_SW   (instret),
        .WAIT_MULT_SW (wait_mult)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge, then let outputs settle away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic put_entry(input logic [31:0] res, input logic [5:0] dest, input logic wb,
                             input logic csr, input logic [31:0] csr_data, input logic mult);
        bus.MEM_RES_RM       = res;
        bus.MEM_DEST_RM      = dest;
        bus.WB_RM            = wb;
        bus.CSR_WENABLE_RM   = csr;
        bus.CSR_RDATA_RM     = csr_data;
        bus.MULT_INST_RM     = mult;
        bus.MEM2WBK_EMPTY_SM = 1'b0;
    endtask

    task automatic drain();
        bus.MEM2WBK_EMPTY_SM = 1'b1;
        bus.MULT_INST_RM     = 1'b0;
        bus.CSR_WENABLE_RM   = 1'b0;
        bus.WB_RM            = 1'b0;
        bus.MULT_EMPTY_SX    = 1'b1;
    endtask

    initial begin
        reset_n           = 1'b0;
        radr1             = 5'd0;
        radr2             = 5'd0;
        bus.MULT_RES_RX   = 32'h0;
        bus.MULT_EMPTY_SX = 1'b0;
        // A visible entry during reset must not be popped.
        put_entry(32'h1111_1111, 6'd4, 1'b1, 1'b0, 32'h0, 1'b0);

        // 1. Reset for two cycles.
        settle();
        chk("rst_mem_pop", 64'(bus.MEM2WBK_POP_SW), 64'd0);
        chk("rst_mult_pop", 64'(bus.MULT_POP_SW), 64'd0);
        tick();
        tick();
        chk("rst_mem_pop2", 64'(bus.MEM2WBK_POP_SW), 64'd0);
        chk("rst_reg_wb", 64'(reg_wb), 64'd0);
        chk("rst_instret", instret, 64'd0);
        chk("rst_wait", 64'(wait_mult), 64'd0);
        drain();
        reset_n = 1'b1;
        for (int a = 0; a < 32; a++) begin
            radr1 = 5'(a);
            radr2 = 5'(31 - a);
            settle();
            chk("rst_rdata1", 64'(rdata1), 64'd0);
            chk("rst_rdata2", 64'(rdata2), 64'd0);
        end
        tick();

        // 2. Plain writeback to x5.
        put_entry(32'hDEAD_BEEF, 6'd5, 1'b1, 1'b0, 32'h0, 1'b0);
        settle();
        chk("t2_pop", 64'(bus.MEM2WBK_POP_SW), 64'd1);
        chk("t2_mult_pop", 64'(bus.MULT_POP_SW), 64'd0);
        chk("t2_reg_wb", 64'(reg_wb), 64'd1);
        chk("t2_reg_dest", 64'(reg_dest), 64'd5);
        chk("t2_reg_data", 64'(reg_data), 64'hDEAD_BEEF);
        tick();
        drain();
        radr1 = 5'd5;
        settle();
        chk("t2_x5", 64'(rdata1), 64'hDEAD_BEEF);
        chk("t2_instret", instret, 64'd1);

        // 3. Mult entry stalls three cycles, then both FIFOs pop together.
        put_entry(32'h0000_0111, 6'd10, 1'b1, 1'b0, 32'h0, 1'b1);
        bus.MULT_EMPTY_SX = 1'b1;
        settle();
        chk("t3_run_pop", 64'(bus.MEM2WBK_POP_SW), 64'd0);
        chk("t3_run_wait", 64'(wait_mult), 64'd0);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("t3_wait", 64'(wait_mult), 64'd1);
            chk("t3_no_pop", 64'(bus.MEM2WBK_POP_SW), 64'd0);
            chk("t3_no_mpop", 64'(bus.MULT_POP_SW), 64'd0);
        end
        chk("t3_instret_held", instret, 64'd1);
        bus.MULT_RES_RX   = 32'h1234_5678;
        bus.MULT_EMPTY_SX = 1'b0;
        settle();
        chk("t3_pop", 64'(bus.MEM2WBK_POP_SW), 64'd1);
        chk("t3_mpop", 64'(bus.MULT_POP_SW), 64'd1);
        chk("t3_data", 64'(reg_data), 64'h1234_5678);
        tick();
        drain();
        radr2 = 5'd10;
        settle();
        chk("t3_x10", 64'(rdata2), 64'h1234_5678);
        chk("t3_wait_off", 64'(wait_mult), 64'd0);
        chk("t3_instret", instret, 64'd2);

        // Non-mult entry with multiplier FIFO non-empty: multiplier FIFO untouched.
        put_entry(32'h0000_0077, 6'd3, 1'b1, 1'b0, 32'h0, 1'b0);
        bus.MULT_EMPTY_SX = 1'b0;
        bus.MULT_RES_RX   = 32'h0000_0999;
        settle();
        chk("nm_pop", 64'(bus.MEM2WBK_POP_SW), 64'd1);
        chk("nm_mpop", 64'(bus.MULT_POP_SW), 64'd0);
        chk("nm_data", 64'(reg_data), 64'h77);
        tick();

        // 4. CSR entry writes old CSR value, then a write to x0 is dropped.
        put_entry(32'h0000_0055, 6'd7, 1'b1, 1'b1, 32'h0000_1800, 1'b0);
        settle();
        chk("t4_csr_data", 64'(reg_data), 64'h1800);
        tick();
        put_entry(32'hFFFF_FFFF, 6'd0, 1'b1, 1'b0, 32'h0, 1'b0);
        settle();
        chk("t4_x0_pop", 64'(bus.MEM2WBK_POP_SW), 64'd1);
        chk("t4_x0_wb", 64'(reg_wb), 64'd0);
        tick();
        drain();
        radr1 = 5'd7;
        radr2 = 5'd0;
        settle();
        chk("t4_x7", 64'(rdata1), 64'h1800);
        chk("t4_x0", 64'(rdata2), 64'd0);
        chk("t4_instret", instret, 64'd5);

        // Mult result wins over CSR data.
        put_entry(32'h0000_0001, 6'd12, 1'b1, 1'b1, 32'h0000_2222, 1'b1);
        bus.MULT_EMPTY_SX = 1'b0;
        bus.MULT_RES_RX   = 32'hCAFE_0000;
        settle();
        chk("prio_data", 64'(reg_data), 64'hCAFE_0000);
        chk("prio_mpop", 64'(bus.MULT_POP_SW), 64'd1);
        tick();

        // WB=0 entry retires without writing.
        put_entry(32'h0000_0BAD, 6'd8, 1'b0, 1'b0, 32'h0, 1'b0);
        settle();
        chk("nowb_pop", 64'(bus.MEM2WBK_POP_SW), 64'd1);
        chk("nowb_wb", 64'(reg_wb), 64'd0);
        tick();
        // Destination bit 5 does not affect the register address.
        put_entry(32'h0000_0B0B, 6'h2B, 1'b1, 1'b0, 32'h0, 1'b0);
        settle();
        chk("d5_dest", 64'(reg_dest), 64'd11);
        chk("d5_wb", 64'(reg_wb), 64'd1);
        tick();
        drain();
        radr1 = 5'd8;
        radr2 = 5'd11;
        settle();
        chk("nowb_x8", 64'(rdata1), 64'd0);
        chk("d5_x11", 64'(rdata2), 64'h0B0B);
        chk("nowb_instret", instret, 64'd8);
        radr1 = 5'd12;
        settle();
        chk("prio_x12", 64'(rdata1), 64'hCAFE_0000);

        // 5. Read of the register being written in the same cycle.
        put_entry(32'hA5A5_A5A5, 6'd9, 1'b1, 1'b0, 32'h0, 1'b0);
        radr1 = 5'd9;
        settle();
`ifdef WBK_RF_BYPASS_EN
        chk("t5_same_cycle", 64'(rdata1), 64'hA5A5_A5A5);
`else
        chk("t5_same_cycle", 64'(rdata1), 64'd0);
`endif
        tick();
        drain();
        settle();
        chk("t5_next_cycle", 64'(rdata1), 64'hA5A5_A5A5);
        chk("t5_instret", instret, 64'd9);

        // 6. Reset taken while stalled in WAIT_MULT.
        put_entry(32'h0, 6'd13, 1'b1, 1'b0, 32'h0, 1'b1);
        bus.MULT_EMPTY_SX = 1'b1;
        tick();
        chk("t6_wait", 64'(wait_mult), 64'd1);
        reset_n = 1'b0;
        bus.MULT_EMPTY_SX = 1'b0;
        bus.MULT_RES_RX   = 32'h1313_1313;
        settle();
        chk("t6_rst_pop", 64'(bus.MEM2WBK_POP_SW), 64'd0);
        chk("t6_rst_mpop", 64'(bus.MULT_POP_SW), 64'd0);
        tick();
        chk("t6_rst_wait", 64'(wait_mult), 64'd0);
        chk("t6_rst_instret", instret, 64'd0);
        reset_n = 1'b1;
        bus.MULT_EMPTY_SX = 1'b1;
        radr1 = 5'd5;
        settle();
        chk("t6_rst_x5", 64'(rdata1), 64'd0);
        chk("t6_hold_pop", 64'(bus.MEM2WBK_POP_SW), 64'd0);
        tick();
        chk("t6_rewait", 64'(wait_mult), 64'd1);
        bus.MULT_EMPTY_SX = 1'b0;
        settle();
        chk("t6_pop", 64'(bus.MEM2WBK_POP_SW), 64'd1);
        chk("t6_mpop", 64'(bus.MULT_POP_SW), 64'd1);
        tick();
        drain();
        radr1 = 5'd13;
        settle();
        chk("t6_x13", 64'(rdata1), 64'h1313_1313);
        chk("t6_instret", instret, 64'd1);
        chk("t6_wait_off", 64'(wait_mult), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule : tb_wbk_stage
